// File: rtl/dbus_bridge_if.sv
// rtl/dbus_bridge_if.sv - req/gnt/rvalid data bus between the bridge (master) and memory (slave)
interface dbus_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  bus_req_o;
  logic                  bus_we_o;
  logic [ADDR_WIDTH-1:0] bus_addr_o;
  logic [DATA_WIDTH-1:0] bus_wdata_o;
  logic                  bus_gnt_i;
  logic                  bus_rvalid_i;
  logic [DATA_WIDTH-1:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );
endinterface

// File: rtl/dbus_bridge.sv
// rtl/dbus_bridge.sv - single-cycle RAM port to req/gnt/rvalid bus bridge; stores run read-then-write
module dbus_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ce_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  stall_o,
  output logic                  err_o,
  dbus_bridge_if.master         bus
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    MERGE,
    WR_REQ,
    WR_WAIT,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CW-1:0]         cnt_q;
  logic                  err_q;
  logic                  expire;
  logic                  timeout;

  assign expire = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      IDLE:    if (ce_i) state_d = RD_REQ;
      RD_REQ:  if (bus.bus_gnt_i) state_d = RD_WAIT;
      RD_WAIT: begin
        // rvalid wins over expiry in the same cycle
        if (bus.bus_rvalid_i) begin
          state_d = we_q ? MERGE : DONE;
        end else if (expire) begin
          state_d = DONE;
          timeout = 1'b1;
        end
      end
      MERGE:   state_d = WR_REQ;
      WR_REQ:  if (bus.bus_gnt_i) state_d = WR_WAIT;
      WR_WAIT: begin
        if (bus.bus_rvalid_i) begin
          state_d = DONE;
        end else if (expire) begin
          state_d = DONE;
          timeout = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.bus_req_o   = (state_q == RD_REQ) || (state_q == WR_REQ);
    bus.bus_we_o    = (state_q == WR_REQ);
    bus.bus_addr_o  = addr_q & ~(ADDR_WIDTH'(3));
    bus.bus_wdata_o = wdata_q;
    rdata_o         = rdata_q;
    err_o           = err_q;
    case (state_q)
      // IDLE stall follows ce_i directly; gated so reset drops it at once
      IDLE:    stall_o = ce_i & ~rst_i;
      DONE:    stall_o = 1'b0;
      default: stall_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= timeout;
      case (state_q)
        IDLE: begin
          if (ce_i) begin
            addr_q <= addr_i;
            we_q   <= we_i;
          end
        end
        RD_REQ, WR_REQ: begin
          if (bus.bus_gnt_i) cnt_q <= '0;
        end
        RD_WAIT: begin
          if (bus.bus_rvalid_i) rdata_q <= bus.bus_rdata_i;
          else if (expire)      rdata_q <= '0;
          else                  cnt_q   <= cnt_q + CW'(1);
        end
        MERGE: wdata_q <= wdata_i;
        WR_WAIT: begin
          if (!bus.bus_rvalid_i) begin
            if (expire) rdata_q <= '0;
            else        cnt_q   <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_bridge.sv
// tb/tb_dbus_bridge.sv - scoreboard bench for dbus_bridge with a memory-stage driver and a bus memory model
module tb_dbus_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  logic          stall, err;
  logic [7:0]    sbyte;

  dbus_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dbus_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .stall_o(stall), .err_o(err), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { int gd1; int rd1; bit to1; int gd2; int rd2; bit to2; } beh_t;
  typedef struct { logic [31:0] rdata; int err; int stalls; int nwr;
                   logic [31:0] rd_addr; logic [31:0] wr_data; } exp_t;

  beh_t        beh_q[$];
  exp_t        exp_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] bus_mem[logic [31:0]];
  int          n_cmp = 0, n_fail = 0;
  int          n_rd = 0, n_wr = 0;
  logic [31:0] last_rd_addr = 0, last_wr_addr = 0, last_wr_data = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [7:0] b, input logic [1:0] lane);
    logic [31:0] r;
    r = w;
    r[lane*8 +: 8] = b;
    return r;
  endfunction

  // memory-stage sub-word merge, combinational from the returned word
  always_comb wdata = merge(rdata, sbyte, addr[1:0]);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic beh_t zero_beh();
    beh_t b;
    b = '{gd1: 0, rd1: 0, to1: 1'b0, gd2: 0, rd2: 0, to2: 1'b0};
    return b;
  endfunction

  function automatic beh_t rand_beh();
    beh_t b;
    b.gd1 = ($urandom % 5 == 0) ? 4 + $urandom % 4 : $urandom % 3;
    b.rd1 = ($urandom % 12 == 0) ? TO - 1 : $urandom % 5;
    b.to1 = ($urandom % 20 == 0);
    b.gd2 = ($urandom % 5 == 0) ? 4 + $urandom % 4 : $urandom % 3;
    b.rd2 = ($urandom % 12 == 0) ? TO - 1 : $urandom % 5;
    b.to2 = ($urandom % 20 == 0);
    return b;
  endfunction

  // Wait for the cycle where the pipeline advances, then step to just after that edge
  task automatic wait_adv();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      n++;
      if (n > 1000) begin
        n_fail++;
        $display("FAIL advance_timeout: stall still %0b after %0d cycles", stall, n);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "advance timeout");
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit w, input logic [31:0] a, input logic [7:0] b, input beh_t bh);
    exp_t        e;
    logic [31:0] wa, old;
    wa  = {a[31:2], 2'b00};
    old = ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
    e.rd_addr = wa;
    e.wr_data = 0;
    if (!w || bh.to1) begin
      e.rdata  = bh.to1 ? 32'h0 : old;
      e.err    = bh.to1;
      e.nwr    = 0;
      e.stalls = 1 + (bh.gd1 + 1) + (bh.to1 ? TO : bh.rd1 + 1);
    end else begin
      e.wr_data   = merge(old, b, a[1:0]);
      ref_mem[wa] = e.wr_data;
      e.rdata     = bh.to2 ? 32'h0 : old;
      e.err       = bh.to2;
      e.nwr       = 1;
      e.stalls    = 1 + (bh.gd1 + 1) + (bh.rd1 + 1) + 1 + (bh.gd2 + 1) + (bh.to2 ? TO : bh.rd2 + 1);
    end
    exp_q.push_back(e);
    beh_q.push_back(bh);
    ce = 1'b1; we = w; addr = a; sbyte = b;
    wait_adv();
  endtask

  task automatic bubble();
    ce = 1'b0; we = $urandom % 2; addr = $urandom; sbyte = $urandom;
    wait_adv();
  endtask

  // Bus memory: grant after gd cycles, respond after rd wait cycles or never on timeout
  initial begin : bus_slave
    int          sph, gcnt, wcnt, rdv;
    bit          tov, cur_we;
    beh_t        cur;
    logic [31:0] ref_addr;
    sph = 0; gcnt = 0; wcnt = 0; rdv = 0; tov = 0; cur_we = 0; ref_addr = 0;
    cur = zero_beh();
    bus.bus_gnt_i = 0; bus.bus_rvalid_i = 0; bus.bus_rdata_i = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        sph = 0; bus.bus_gnt_i = 0; bus.bus_rvalid_i = 0;
      end else begin
        if (sph == 0) begin
          bus.bus_gnt_i = 0; bus.bus_rvalid_i = 0;
          if (bus.bus_req_o) begin
            cur_we   = bus.bus_we_o;
            ref_addr = bus.bus_addr_o;
            if (!cur_we) begin
              if (beh_q.size() == 0) begin
                chk("beh_queue_empty", 32'h0, 32'h1);
                cur = zero_beh();
              end else cur = beh_q.pop_front();
              gcnt = cur.gd1; rdv = cur.rd1; tov = cur.to1;
            end else begin
              gcnt = cur.gd2; rdv = cur.rd2; tov = cur.to2;
            end
            sph = 1;
          end
        end else if (sph == 1) begin
          chk("req_hold_ctl", {30'h0, bus.bus_req_o, bus.bus_we_o}, {30'h0, 1'b1, cur_we});
          chk("req_hold_addr", bus.bus_addr_o, ref_addr);
        end
        if (sph == 1) begin
          if (gcnt == 0) begin
            bus.bus_gnt_i = 1; bus.bus_rvalid_i = 0;
            if (cur_we) begin
              n_wr++;
              last_wr_addr = bus.bus_addr_o;
              last_wr_data = bus.bus_wdata_o;
              bus_mem[bus.bus_addr_o] = bus.bus_wdata_o;
            end else begin
              n_rd++;
              last_rd_addr = bus.bus_addr_o;
            end
            wcnt = 0;
            sph  = 2;
          end else begin
            bus.bus_gnt_i    = 0;
            bus.bus_rvalid_i = $urandom % 2;
            bus.bus_rdata_i  = $urandom;
            gcnt--;
          end
        end else if (sph == 2) begin
          bus.bus_gnt_i = 0;
          if (!tov && wcnt == rdv) begin
            bus.bus_rvalid_i = 1;
            if (cur_we) bus.bus_rdata_i = $urandom;
            else bus.bus_rdata_i = bus_mem.exists(ref_addr) ? bus_mem[ref_addr] : init_word(ref_addr);
            sph = 0;
          end else begin
            bus.bus_rvalid_i = 0;
            bus.bus_rdata_i  = $urandom;
            if (tov && wcnt == TO - 1) sph = 0;
            wcnt++;
          end
        end
      end
    end
  end

  // Scoreboard monitor: a DONE cycle is stall low while the access is still presented
  initial begin : monitor
    int   scnt, ecnt, base_rd, base_wr;
    exp_t e;
    scnt = 0; ecnt = 0; base_rd = 0; base_wr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        scnt = 0; ecnt = 0; base_rd = n_rd; base_wr = n_wr;
      end else begin
        if (stall) scnt++;
        if (err) ecnt++;
        if (!stall) begin
          if (ce) begin
            if (exp_q.size() == 0) chk("unexpected_done", 32'h0, 32'h1);
            else begin
              e = exp_q.pop_front();
              chk("rdata", rdata, e.rdata);
              chk("err_pulses", ecnt, e.err);
              chk("stall_cycles", scnt, e.stalls);
              chk("read_count", n_rd - base_rd, 1);
              chk("read_addr", last_rd_addr, e.rd_addr);
              chk("write_count", n_wr - base_wr, e.nwr);
              if (e.nwr == 1) begin
                chk("write_addr", last_wr_addr, e.rd_addr);
                chk("write_data", last_wr_data, e.wr_data);
              end
            end
          end else if (ecnt != 0) chk("idle_err", ecnt, 0);
          scnt = 0; ecnt = 0; base_rd = n_rd; base_wr = n_wr;
        end
      end
    end
  end

  initial begin : main
    beh_t b;
    bit   hit;
    rst = 1; ce = 0; we = 0; addr = 0; sbyte = 0;
    ref_mem[32'h1004] = 32'hA1B2C3D4; bus_mem[32'h1004] = 32'hA1B2C3D4;
    ref_mem[32'h2000] = 32'h11223344; bus_mem[32'h2000] = 32'h11223344;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 0);
    chk("rst_ctl", {28'h0, bus.bus_req_o, bus.bus_we_o, stall, err}, 0);
    chk("rst_addr", bus.bus_addr_o, 0);
    chk("rst_wdata", bus.bus_wdata_o, 0);
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1;

    issue(0, 32'h1006, 8'h00, zero_beh());
    issue(1, 32'h2001, 8'hEE, zero_beh());
    issue(0, 32'h2003, 8'h00, zero_beh());
    b = zero_beh(); b.gd1 = 4;             issue(0, 32'h1004, 8'h00, b);
    b = zero_beh(); b.gd2 = 3; b.rd2 = 2;  issue(1, 32'h1006, 8'h5A, b);
    b = zero_beh(); b.to1 = 1;             issue(0, 32'h1008, 8'h00, b);
    b = zero_beh(); b.to1 = 1;             issue(1, 32'h100C, 8'h77, b);
    b = zero_beh(); b.to2 = 1;             issue(1, 32'h1010, 8'h99, b);
    b = zero_beh(); b.rd1 = TO - 1;        issue(0, 32'h1010, 8'h00, b);
    bubble();
    issue(0, 32'h100C, 8'h00, zero_beh());

    // Reset while the write request is being held un-granted
    b = zero_beh(); b.gd2 = 40;
    beh_q.push_back(b);
    ce = 1; we = 1; addr = 32'h1020; sbyte = 8'h42;
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.bus_req_o && bus.bus_we_o) begin hit = 1; break; end
    end
    chk("rst_reach_wr_req", {31'h0, hit}, 1);
    #2 rst = 1;
    #1;
    chk("async_rst_ctl", {29'h0, bus.bus_req_o, bus.bus_we_o, stall}, 0);
    chk("async_rst_rdata", rdata, 0);
    ce = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1;
    issue(0, 32'h1020, 8'h00, zero_beh());

    for (int i = 0; i < 60; i++) begin
      if ($urandom % 8 == 0) bubble();
      else issue($urandom % 2, 32'h3000 + ($urandom % 16) * 4 + $urandom % 4, 8'($urandom), rand_beh());
    end
    ce = 0;
    repeat (4) @(posedge clk);
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dbus_bridge.md
Name: dbus_bridge

Overview:
- Sits directly downstream of the memory-access stage, between its RAM port and the data bus.
- Converts the stage's single-cycle RAM request (chip enable, write request, address, merged write data) into a multi-cycle req/gnt/rvalid bus transaction.
- Stalls the pipeline until the transaction completes.
- Every store runs read-then-write: the memory stage merges sub-word store data into the returned word, so each store needs the old word first.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
TIMEOUT_CYCLES, 64, max cycles waiting for bus_rvalid_i before abort

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
ce_i  in  1  access request from memory stage (its chip-enable output)
we_i  in  1  store request from memory stage
addr_i  in  ADDR_WIDTH  byte address from memory stage
wdata_i  in  DATA_WIDTH  merged store word from memory stage (combinational from rdata_o)
rdata_o  out  DATA_WIDTH  word returned to memory stage RAM-data input
stall_o  out  1  pipeline stall request to control unit
err_o  out  1  one-cycle pulse on bus timeout
bus_req_o  out  1  bus request
bus_we_o  out  1  bus write strobe
bus_addr_o  out  ADDR_WIDTH  word-aligned bus address
bus_wdata_o  out  DATA_WIDTH  bus write data
bus_gnt_i  in  1  bus grant, request accepted
bus_rvalid_i  in  1  response valid; read data valid, or write acknowledge
bus_rdata_i  in  DATA_WIDTH  bus read data

Behaviour:
- Reset (async, any state): state=IDLE; rdata_o, bus_addr_o, bus_wdata_o = 0; bus_req_o, bus_we_o, stall_o, err_o = 0; timeout counter = 0.
- States: IDLE, RD_REQ, RD_WAIT, MERGE, WR_REQ, WR_WAIT, DONE.

State transitions:
- IDLE:
  - If ce_i=1: latch addr_q=addr_i and we_q=we_i, then go to RD_REQ.
  - stall_o = ce_i (combinational) in this state.
- RD_REQ:
  - bus_req_o=1, bus_we_o=0, bus_addr_o={addr_q[ADDR_WIDTH-1:2],2'b00}.
  - Held stable until bus_gnt_i=1, then go to RD_WAIT and clear the counter.
- RD_WAIT:
  - bus_req_o=0.
  - On bus_rvalid_i: capture rdata_q=bus_rdata_i, then go to MERGE if we_q=1, else DONE.
- MERGE (one cycle):
  - rdata_o already shows the old word, so wdata_i is valid.
  - Latch wdata_q=wdata_i, then go to WR_REQ.
- WR_REQ:
  - bus_req_o=1, bus_we_o=1, same aligned address, bus_wdata_o=wdata_q.
  - Held until bus_gnt_i, then go to WR_WAIT and clear the counter.
- WR_WAIT: on bus_rvalid_i (write ack), go to DONE; bus_rdata_i is ignored.
- DONE:
  - stall_o=0 for exactly one cycle; the pipeline advances at the end of this cycle.
  - rdata_o holds the captured word; next state is IDLE.

Outputs and registers:
- stall_o=1 in RD_REQ, RD_WAIT, MERGE, WR_REQ, WR_WAIT. stall_o=0 in DONE.
- rdata_o=rdata_q at all times; it changes only on read capture, timeout, or reset.

Timing and handshake rules:
- Minimum latency with a zero-wait bus (gnt in the request cycle, rvalid the next cycle):
  - Load: stall high for 3 cycles (IDLE, RD_REQ, RD_WAIT), then DONE.
  - Store: stall high for 6 cycles, then DONE.
- bus_rvalid_i is sampled only in *_WAIT states; rvalid in a REQ cycle is ignored (bus guarantees rvalid no earlier than the cycle after gnt).

Timeout:
- A counter increments each WAIT cycle without rvalid.
- When it reaches TIMEOUT_CYCLES-1 without rvalid: err_o pulses one cycle, rdata_q=0, go to DONE.
- A read timeout on a store skips the write phase.
- rvalid arriving in the same cycle as expiry takes priority (normal completion, no err_o).

Boundary cases:
- ce_i dropping mid-transaction (flush): ignored; once RD_REQ is entered, the transaction runs to DONE.
- Back-to-back accesses: ce_i sampled in the IDLE cycle after DONE starts the next access. No access is lost or duplicated.
- Address bits [1:0] are never driven on the bus; byte selection is done by the memory stage.

Test Plan:
- Load, zero-wait bus: ce_i=1, we_i=0, addr_i=0x1006, rdata=0xA1B2C3D4 -> bus_addr_o=0x1004, stall_o high 3 cycles, DONE with rdata_o=0xA1B2C3D4, single bus_req_o cycle with bus_we_o=0.
- Byte store: addr_i=0x2001, bus read returns 0x11223344, memory-stage model merges byte 0xEE -> write phase bus_wdata_o=0x1122EE44, bus_we_o=1, stall low only in DONE (cycle 7).
- Grant wait states: bus_gnt_i held low 4 cycles -> bus_req_o, bus_addr_o, bus_we_o stable all 4 cycles, stall_o high throughout.
- Timeout: no rvalid for TIMEOUT_CYCLES=64 after gnt -> err_o single pulse, rdata_o=0, DONE; for a store, no write request is issued.
- Reset mid-WR_REQ: assert rst_i asynchronously -> bus_req_o, bus_we_o, stall_o fall immediately without a clock edge; rdata_o=0; after release, a new load completes normally.
- Back-to-back load then store with ce_i continuously high -> exactly one read transaction, then one read+write pair; two DONE cycles total.
